reduce_gate_pipe: RTL and testbench

//   Parametrised N-input, W-bit bitwise reduction gate (AND/OR/XOR/NAND, selectable per

---
 rtl/reduce_gate_pipe.sv | 159 +++++++++++++++
 tb/tb_reduce_gate_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe
//   N_IN-operand, WIDTH-bit bitwise reduction (AND/OR/XOR/NAND, chosen per
//   transaction) behind a valid/ready input, feeding a DEPTH-entry result FIFO.
//
// Ports
//   clk, rst    rising-edge clock, synchronous active-high reset
//   in_valid    operand set valid
//   in_ready    block can accept an operand set (level < DEPTH)
//   in_data     packed operands, operand k = in_data[k*WIDTH +: WIDTH]
//   in_op       00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid   FIFO head holds a result
//   out_ready   downstream accepts the head
//   out_data    result at FIFO head (last popped value when empty)
//   out_op      op that produced out_data
//   level       FIFO occupancy, 0..DEPTH
//   txn_cnt     accepted transactions, saturating
module reduce_gate_pipe #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [1:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             out_op,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       txn_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    logic [WIDTH-1:0] data_mem_q [DEPTH];
    op_e              op_mem_q   [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] last_data_q, last_data_d;
    op_e              last_op_q, last_op_d;

    logic             push;
    logic             pop;
    op_e              op_in;
    logic [WIDTH-1:0] red_and;
    logic [WIDTH-1:0] red_or;
    logic [WIDTH-1:0] red_xor;
    logic [WIDTH-1:0] result;

    // Ready/valid come from registered occupancy only, so a pop in the same
    // cycle never opens the input while full.
    assign in_ready  = (level_q < FULL_LVL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign op_in     = op_e'(in_op);

    always_comb begin
        red_and = '1;
        red_or  = '0;
        red_xor = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            red_and = red_and & in_data[k*WIDTH +: WIDTH];
            red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
            red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result = '0;
        case (op_in)
            OP_AND:  result = red_and;
            OP_OR:   result = red_or;
            OP_XOR:  result = red_xor;
            OP_NAND: result = ~red_and;
            default: result = '0;
        endcase
    end

    // Pointers are PW bits wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        last_op_d   = last_op_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            last_data_d = data_mem_q[rd_ptr_q];
            last_op_d   = op_mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            last_data_q <= '0;
            last_op_q   <= OP_AND;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            last_op_q   <= last_op_d;
        end
    end

    // Storage needs no reset: an entry is only read while level covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= result;
            op_mem_q[wr_ptr_q]   <= op_in;
        end
    end

    // The head is read straight from storage; the last popped entry is kept
    // so the outputs hold their value once the FIFO drains.
    assign out_data = out_valid ? data_mem_q[rd_ptr_q] : last_data_q;
    assign out_op   = out_valid ? op_mem_q[rd_ptr_q]   : last_op_q;
    assign level    = level_q;
    assign txn_cnt  = cnt_q;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
module tb_reduce_gate_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: 3 x 1-bit, DEPTH 2, 4-bit counter
    logic       va, ora;
    logic [2:0] da;
    logic [1:0] opa;
    logic       rdy_a, ova;
    logic [0:0] oda;
    logic [1:0] opoa;
    logic [1:0] lvla;
    logic [3:0] cnta;

    reduce_gate_pipe #(.N_IN(3), .WIDTH(1), .DEPTH(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(va), .in_ready(rdy_a), .in_data(da), .in_op(opa),
        .out_valid(ova), .out_ready(ora), .out_data(oda), .out_op(opoa),
        .level(lvla), .txn_cnt(cnta)
    );

    // Instance B: 4 x 8-bit, DEPTH 4, 16-bit counter
    logic        vb, orb;
    logic [31:0] db;
    logic [1:0]  opb;
    logic        rdy_b, ovb;
    logic [7:0]  odb;
    logic [1:0]  opob;
    logic [2:0]  lvlb;
    logic [15:0] cntb;

    reduce_gate_pipe #(.N_IN(4), .WIDTH(8), .DEPTH(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(vb), .in_ready(rdy_b), .in_data(db), .in_op(opb),
        .out_valid(ovb), .out_ready(orb), .out_data(odb), .out_op(opob),
        .level(lvlb), .txn_cnt(cntb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per bit position: count the ones across operands, then apply the op rule.
    function automatic int ref_red(input logic [31:0] data, input int op, input int n, input int w);
        int r;
        r = 0;
        for (int b = 0; b < w; b++) begin
            int ones;
            bit bv;
            ones = 0;
            for (int k = 0; k < n; k++) ones += int'(data[k*w + b]);
            case (op)
                0:       bv = (ones == n);
                1:       bv = (ones > 0);
                2:       bv = (ones % 2) == 1;
                default: bv = (ones != n);
            endcase
            if (bv) r += (1 << b);
        end
        return r;
    endfunction

    typedef struct { int d; int op; } ent_t;

    // Model A
    ent_t qa[$];
    int   last_da, last_opa, cnt_ma;
    bit   arm_a = 0, pushed_a = 0;

    always @(posedge clk) begin
        if (rst) begin
            qa.delete(); last_da = 0; last_opa = 0; cnt_ma = 0; arm_a = 1; pushed_a = 0;
        end else if (arm_a) begin
            bit push, pop;
            ent_t e;
            push = va && (qa.size() < 2);
            pop  = (qa.size() > 0) && ora;
            pushed_a = push;
            if (pop) begin
                last_da = qa[0].d; last_opa = qa[0].op; void'(qa.pop_front());
            end
            if (push) begin
                e.d = ref_red(32'(da), int'(opa), 3, 1); e.op = int'(opa);
                qa.push_back(e);
                if (cnt_ma < 15) cnt_ma++;
            end
        end
    end

    // Model B
    ent_t qb[$];
    int   last_db, last_opb, cnt_mb;
    bit   arm_b = 0, pushed_b = 0;

    always @(posedge clk) begin
        if (rst) begin
            qb.delete(); last_db = 0; last_opb = 0; cnt_mb = 0; arm_b = 1; pushed_b = 0;
        end else if (arm_b) begin
            bit push, pop;
            ent_t e;
            push = vb && (qb.size() < 4);
            pop  = (qb.size() > 0) && orb;
            pushed_b = push;
            if (pop) begin
                last_db = qb[0].d; last_opb = qb[0].op; void'(qb.pop_front());
            end
            if (push) begin
                e.d = ref_red(db, int'(opb), 4, 8); e.op = int'(opb);
                qb.push_back(e);
                if (cnt_mb < 65535) cnt_mb++;
            end
        end
    end

    // Cycle-by-cycle comparison against both models
    always @(negedge clk) begin
        if (arm_a) begin
            chk("a_in_ready",  32'(rdy_a), 32'(qa.size() < 2));
            chk("a_out_valid", 32'(ova),   32'(qa.size() > 0));
            chk("a_level",     32'(lvla),  32'(qa.size()));
            chk("a_txn_cnt",   32'(cnta),  32'(cnt_ma));
            chk("a_out_data",  32'(oda),   32'((qa.size() > 0) ? qa[0].d  : last_da));
            chk("a_out_op",    32'(opoa),  32'((qa.size() > 0) ? qa[0].op : last_opa));
        end
        if (arm_b) begin
            chk("b_in_ready",  32'(rdy_b), 32'(qb.size() < 4));
            chk("b_out_valid", 32'(ovb),   32'(qb.size() > 0));
            chk("b_level",     32'(lvlb),  32'(qb.size()));
            chk("b_txn_cnt",   32'(cntb),  32'(cnt_mb));
            chk("b_out_data",  32'(odb),   32'((qb.size() > 0) ? qb[0].d  : last_db));
            chk("b_out_op",    32'(opob),  32'((qb.size() > 0) ? qb[0].op : last_opb));
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] exp_b [4];
        rst = 1'b1; va = 1'b1; da = '0; opa = '0; ora = 1'b0;
        vb = 1'b0; db = '0; opb = '0; orb = 1'b0;

        // Pin the reference model with hand-computed values
        chk("pin_and_111",  32'(ref_red(32'h7, 0, 3, 1)), 32'h1);
        chk("pin_xor_110",  32'(ref_red(32'h6, 2, 3, 1)), 32'h0);
        chk("pin_nand_000", 32'(ref_red(32'h0, 3, 3, 1)), 32'h1);
        chk("pin_xor_w8",   32'(ref_red(32'h0FFF3CF0, 2, 4, 8)), 32'h3C);

        // Reset held two cycles with in_valid high
        cyc(); cyc();
        chk("rst_level_a", 32'(lvla), 32'h0);
        chk("rst_valid_a", 32'(ova),  32'h0);
        chk("rst_cnt_a",   32'(cnta), 32'h0);
        chk("rst_ready_a", 32'(rdy_a), 32'h1);
        chk("rst_data_a",  32'(oda),  32'h0);
        chk("rst_level_b", 32'(lvlb), 32'h0);
        rst = 1'b0; va = 1'b0;
        cyc();

        // Truth table on A, streaming with out_ready high
        ora = 1'b1;
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 8; i++) begin
                va = 1'b1; da = 3'(i); opa = 2'(op);
                cyc();
                chk("tt_head", 32'(oda), 32'(ref_red(32'(i), op, 3, 1)));
                if (i == 7 && op == 0) chk("tt_111_and", 32'(oda), 32'h1);
                if (i == 6 && op == 2) chk("tt_110_xor", 32'(oda), 32'h0);
                if (i == 0 && op == 3) chk("tt_000_nand", 32'(oda), 32'h1);
            end
        end
        va = 1'b0;
        cyc();

        // Wide operands on B, queued then drained
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C; exp_b[3] = 8'hFF;
        orb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vb = 1'b1; db = 32'h0FFF3CF0; opb = 2'(k);
            cyc();
        end
        vb = 1'b0;
        chk("b_full_level", 32'(lvlb), 32'h4);
        chk("b_full_ready", 32'(rdy_b), 32'h0);
        orb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("b_vec_data", 32'(odb), 32'(exp_b[k]));
            chk("b_vec_op",   32'(opob), 32'(k));
            cyc();
        end
        chk("b_drained", 32'(lvlb), 32'h0);

        // Backpressure and full+pop on A
        ora = 1'b0;
        va = 1'b1; da = 3'b101; opa = 2'd1; cyc();
        da = 3'b011; opa = 2'd2; cyc();
        chk("bp_level2", 32'(lvla), 32'h2);
        chk("bp_ready0", 32'(rdy_a), 32'h0);
        da = 3'b110; opa = 2'd3; cyc();
        chk("bp_held",   32'(lvla), 32'h2);
        cyc();
        ora = 1'b1; cyc();
        chk("full_pop_only", 32'(lvla), 32'h1);
        chk("full_pop_head", 32'(oda),  32'h0);
        cyc();
        chk("push_pop_keep", 32'(lvla), 32'h1);
        chk("push_pop_head", 32'(oda),  32'h1);
        chk("push_pop_op",   32'(opoa), 32'h3);
        va = 1'b0; cyc();
        chk("bp_drained", 32'(lvla), 32'h0);

        // Counter saturation, then reset with a full FIFO
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            va = 1'b1; da = 3'($urandom); opa = 2'($urandom);
            cyc();
        end
        chk("sat_cnt", 32'(cnta), 32'hF);
        ora = 1'b0; cyc();
        chk("sat_level2", 32'(lvla), 32'h2);
        rst = 1'b1; cyc();
        chk("midrst_level", 32'(lvla), 32'h0);
        chk("midrst_valid", 32'(ova),  32'h0);
        chk("midrst_cnt",   32'(cnta), 32'h0);
        rst = 1'b0; va = 1'b0;

        // Random traffic on A, source holds an unaccepted set stable
        for (int c = 0; c < 1500; c++) begin
            if (!(va && !pushed_a)) begin
                va = 1'($urandom_range(0, 1)); da = 3'($urandom); opa = 2'($urandom);
            end
            ora = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0; va = 1'b0; ora = 1'b1;

        // Random traffic on B
        for (int c = 0; c < 1500; c++) begin
            if (!(vb && !pushed_b)) begin
                vb = 1'($urandom_range(0, 1)); db = $urandom; opb = 2'($urandom);
            end
            orb = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0; vb = 1'b0; orb = 1'b1;
        repeat (6) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
